// File: rtl/filter_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : filter_out_fifo
// Brief    : Show-ahead output FIFO for a filter chain (no upstream
//            backpressure), with a sticky overflow flag and saturating drop count.
// Revision : 1.0 - initial release
// ============================================================================
module filter_out_fifo #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              io_x_data,
    input  logic                     io_x_valid,
    input  logic                     io_x_parity,
    output logic [15:0]              io_y_data,
    output logic                     io_y_valid,
    output logic                     io_y_parity,
    input  logic                     io_y_ready,
    input  logic                     io_clear,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic                     io_overflow,
    output logic [DROP_W-1:0]        io_drops
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [16:0]       r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drops;

    logic              w_nonempty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [16:0]       w_head;

    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty & io_y_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = io_x_valid & ((r_count != c_FULL) | w_pop);
    assign w_drop     = io_x_valid & ~w_push;

    assign w_head      = w_nonempty ? r_mem[r_rd_ptr] : 17'h0;
    assign io_y_data   = w_head[15:0];
    assign io_y_parity = w_head[16];
    assign io_y_valid  = w_nonempty;
    assign io_count    = r_count;
    assign io_overflow = r_overflow;
    assign io_drops    = r_drops;

    // Storage is intentionally left unreset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {io_x_parity, io_x_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear wins: the count restarts at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (io_clear) begin
                r_drops <= DROP_W'(1);
            end else if (r_drops != '1) begin
                r_drops <= r_drops + DROP_W'(1);
            end
        end else if (io_clear) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_filter_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_out_fifo
// Brief    : Directed scoreboard bench for filter_out_fifo (DEPTH=4, DROP_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_out_fifo;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 2;
    localparam int c_CW   = $clog2(DEPTH) + 1;
    localparam int c_DMAX = (1 << DROP_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [15:0]        io_x_data = '0;
    logic               io_x_valid = 1'b0;
    logic               io_x_parity = 1'b0;
    logic [15:0]        io_y_data;
    logic               io_y_valid;
    logic               io_y_parity;
    logic               io_y_ready = 1'b0;
    logic               io_clear = 1'b0;
    logic [c_CW-1:0]    io_count;
    logic               io_overflow;
    logic [DROP_W-1:0]  io_drops;

    int n_asserts = 0;
    int n_fails   = 0;

    logic [16:0] sb_q[$];
    int          m_ovf   = 0;
    int          m_drops = 0;

    filter_out_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .io_x_data   (io_x_data),
        .io_x_valid  (io_x_valid),
        .io_x_parity (io_x_parity),
        .io_y_data   (io_y_data),
        .io_y_valid  (io_y_valid),
        .io_y_parity (io_y_parity),
        .io_y_ready  (io_y_ready),
        .io_clear    (io_clear),
        .io_count    (io_count),
        .io_overflow (io_overflow),
        .io_drops    (io_drops)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [16:0] head;
        head = (sb_q.size() != 0) ? sb_q[0] : 17'h0;
        check({tag, ".count"}, 32'(io_count), 32'(sb_q.size()));
        check({tag, ".valid"}, 32'(io_y_valid), 32'(sb_q.size() != 0));
        check({tag, ".head"}, 32'({io_y_parity, io_y_data}), 32'(head));
        check({tag, ".ovf"}, 32'(io_overflow), 32'(m_ovf));
        check({tag, ".drops"}, 32'(io_drops), 32'(m_drops));
    endtask

    // Called at the falling edge: drive, predict, clock, then re-check.
    task automatic step(input string tag, input logic xv, input logic [15:0] xd,
                        input logic xp, input logic rdy, input logic clr);
        int  size_before;
        bit  pop, push, drop;
        io_x_valid  = xv;
        io_x_data   = xd;
        io_x_parity = xp;
        io_y_ready  = rdy;
        io_clear    = clr;
        #1;
        size_before = sb_q.size();
        pop  = (size_before != 0) && rdy;
        push = xv && ((size_before != DEPTH) || pop);
        drop = xv && !push;
        if (pop) begin
            check({tag, ".pop"}, 32'({io_y_parity, io_y_data}), 32'(sb_q[0]));
            void'(sb_q.pop_front());
        end
        if (push) sb_q.push_back({xp, xd});
        if (drop) begin
            m_ovf   = 1;
            m_drops = clr ? 1 : ((m_drops == c_DMAX) ? c_DMAX : m_drops + 1);
        end else if (clr) begin
            m_ovf   = 0;
            m_drops = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        logic [15:0] rd;
        #1;
        check_state("reset_hold");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) step("idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        step("push1", 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        step("push2", 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        step("push3", 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("drain3", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        for (int i = 1; i <= 6; i++) step("ovf_push", 1'b1, 16'(16'h0100 + i), 1'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("ovf_drain", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) step("fill", 1'b1, 16'(16'h0A00 + i), 1'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rd = 16'($urandom);
            step("full_flow", 1'b1, rd, rd[0], 1'b1, 1'b0);
        end
        for (int i = 0; i < 5; i++) step("flow_drain", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        step("clear_only", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) step("fill2", 1'b1, 16'(16'h0B00 + i), 1'b1, 1'b0, 1'b0);
        step("drop_clear", 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
        step("clear2", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("sat_drop", 1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
        step("clear3", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step("pop_one", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with three entries stored.
        io_y_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        sb_q.delete();
        m_ovf   = 0;
        m_drops = 0;
        check_state("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_state("rst_held");
        reset = 1'b0;
        step("beef", 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        step("beef_pop", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_out_fifo.md
Name: filter_out_fifo

Overview:
- Buffers the output stream of a filter chain and converts it to a ready/valid handshake for downstream consumers.
- The upstream filter has no backpressure. Every valid beat is either stored or dropped and counted.
- Stores data and parity together. Reports occupancy, a sticky overflow flag and a saturating drop count.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two, >= 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_x_data  in  16  input beat data (upstream filter io_y_data).
- io_x_valid  in  1  input beat valid; no ready is returned upstream.
- io_x_parity  in  1  input beat parity bit.
- io_y_data  out  16  head-of-FIFO data.
- io_y_valid  out  1  FIFO non-empty.
- io_y_parity  out  1  head-of-FIFO parity.
- io_y_ready  in  1  downstream accepts the head beat.
- io_clear  in  1  clears io_overflow and io_drops.
- io_count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- io_overflow  out  1  sticky: at least one beat dropped since reset/clear.
- io_drops  out  DROP_W  number of dropped beats, saturating at all-ones.

Behaviour:
- Storage: DEPTH entries of 17 bits {parity, data[15:0]}. Entries are not reset.
- Write pointer, read pointer and count are registered; pointers wrap modulo DEPTH.
- Reset (asynchronous assert, takes effect immediately):
  - pointers = 0, count = 0, io_overflow = 0, io_drops = 0.
  - Hence io_y_valid = 0, io_y_data = 16'h0, io_y_parity = 0 while reset is held and after release.
- pop = io_y_valid & io_y_ready.
- push = io_x_valid & (count != DEPTH | pop).
  - When full, a simultaneous pop frees the slot and the incoming beat is accepted.
- drop = io_x_valid & ~push, i.e. full with no pop in the same cycle.
- Show-ahead head:
  - io_y_data/io_y_parity = entry at the read pointer when count != 0, else forced to 0.
  - io_y_valid = (count != 0).
- Latency: a beat pushed at edge t is visible on io_y_* after edge t when the FIFO was empty. There is no combinational input-to-output path.
- Head stability: while io_y_valid = 1 and io_y_ready = 0, io_y_data/io_y_parity remain constant.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on both or neither.
- Empty with io_x_valid and io_y_ready both high: push only; pop cannot occur because io_y_valid = 0.
- io_y_ready while empty is ignored.
- Overflow/drop update per cycle:
  - drop & ~io_clear: io_overflow <= 1; io_drops <= io_drops + 1, saturating at 2^DROP_W - 1.
  - io_clear & ~drop: io_overflow <= 0; io_drops <= 0.
  - io_clear & drop: set wins; io_overflow <= 1; io_drops <= 1.
- FIFO contents and ordering are never affected by io_clear.
- Parity is stored and forwarded unmodified; this block performs no checking.
- Reset asserted mid-stream discards all stored beats immediately. The first beat after release is accepted into an empty FIFO.
- io_x_data/io_x_parity are ignored when io_x_valid = 0.

Test Plan:
- Reset then idle 5 cycles:
  - io_y_valid = 0, io_y_data = 0, io_count = 0, io_overflow = 0, io_drops = 0 throughout.
- Push 3 beats (16'h0001/p0, 16'h0002/p1, 16'h00FF/p0) with io_y_ready = 0:
  - io_count goes 1, 2, 3.
  - Head holds 16'h0001/p0.
  - Then io_y_ready = 1: outputs 0001, 0002, 00FF in order on consecutive cycles; io_valid falls after the third.
- Push 6 beats back-to-back with DEPTH = 4, io_y_ready = 0:
  - io_count saturates at 4.
  - io_overflow = 1 from the cycle after beat 5; io_drops = 2.
  - Drain yields beats 1–4 only.
- Full FIFO, io_x_valid = 1 and io_y_ready = 1 for 10 cycles:
  - io_count stays 4, no drops, output order matches input order.
- Drop coinciding with io_clear: io_overflow = 1, io_drops = 1 (set wins).
- Drop counter saturation with DROP_W = 2: five drops give io_drops = 3.
- io_clear alone gives io_overflow = 0, io_drops = 0.
- Assert reset asynchronously mid-cycle with 3 entries stored:
  - io_y_valid and io_count drop to 0 before the next clk edge.
  - After release, pushing 16'hBEEF/p1 shows it at the head one cycle later.
